adder_tree_sequencer: RTL and testbench

// Job controller for one pipelined adder tree. Takes a command (chunk count, sigma tag) and streams

---
 rtl/adder_tree_seq_pkg.sv | 22 ++
 rtl/adder_tree_seq_if.sv | 31 +++
 rtl/adder_tree_sequencer_accumulator.sv | 47 ++++
 rtl/adder_tree_sequencer.sv | 144 ++++++++++++++
 tb/tb_adder_tree_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_tree_seq_pkg.sv
// Shared types and width helpers for the adder tree job sequencer.
package adder_tree_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } seq_state_e;

    // A single-lane tree passes its input straight through, so no growth bits.
    function automatic int unsigned tree_out_width(input int unsigned num_inputs,
                                                   input int unsigned input_width);
        return (num_inputs <= 1) ? input_width : input_width + $clog2(num_inputs);
    endfunction

    function automatic int unsigned acc_width(input int unsigned tree_out_w,
                                              input int unsigned cnt_w);
        return tree_out_w + cnt_w;
    endfunction

endpackage

// File: rtl/adder_tree_seq_if.sv
// Command, chunk-stream and result handshakes of the adder tree job sequencer.
interface adder_tree_seq_if
    import adder_tree_seq_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = 8,
    parameter int unsigned INPUT_WIDTH = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned ACC_W       = acc_width(tree_out_width(NUM_INPUTS, INPUT_WIDTH), CNT_W)
);
    logic                              cmd_valid_i;
    logic                              cmd_ready_o;
    logic [CNT_W-1:0]                  cmd_chunks_i;
    logic                              cmd_sigma_i;
    logic                              in_valid_i;
    logic                              in_ready_o;
    logic [NUM_INPUTS*INPUT_WIDTH-1:0] in_data_i;
    logic                              res_valid_o;
    logic                              res_ready_i;
    logic [ACC_W-1:0]                  res_sum_o;
    logic                              res_sigma_o;

    modport master (
        output cmd_valid_i, cmd_chunks_i, cmd_sigma_i, in_valid_i, in_data_i, res_ready_i,
        input  cmd_ready_o, in_ready_o, res_valid_o, res_sum_o, res_sigma_o
    );

    modport slave (
        input  cmd_valid_i, cmd_chunks_i, cmd_sigma_i, in_valid_i, in_data_i, res_ready_i,
        output cmd_ready_o, in_ready_o, res_valid_o, res_sum_o, res_sigma_o
    );
endinterface

// File: rtl/adder_tree_sequencer_accumulator.sv
// Sums the tree's partial results into one job total and holds it in the result register.
module tree_result_accumulator #(
    parameter int unsigned TREE_OUT_W = 11,
    parameter int unsigned ACC_W      = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  zero_load,
    input  logic                  timeout_load,
    input  logic                  tag,
    input  logic [TREE_OUT_W-1:0] tree_sum_i,
    input  logic                  tree_start_i,
    input  logic                  tree_final_i,
    input  logic                  tree_sigma_i,
    output logic [ACC_W-1:0]      res_sum_o,
    output logic                  res_sigma_o
);
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sum_x;
    logic [ACC_W-1:0] acc_next;

    assign sum_x    = {{(ACC_W-TREE_OUT_W){tree_sum_i[TREE_OUT_W-1]}}, tree_sum_i};
    assign acc_next = tree_start_i ? sum_x : acc_q + sum_x;

    // A timeout publishes whatever has accumulated so far under the job's own tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            res_sum_o   <= '0;
            res_sigma_o <= 1'b0;
        end else if (zero_load) begin
            acc_q       <= '0;
            res_sum_o   <= '0;
            res_sigma_o <= tag;
        end else if (timeout_load) begin
            res_sum_o   <= acc_q;
            res_sigma_o <= tag;
        end else if (en) begin
            acc_q <= acc_next;
            if (tree_final_i) begin
                res_sum_o   <= acc_next;
                res_sigma_o <= tree_sigma_i;
            end
        end
    end
endmodule

// File: rtl/adder_tree_sequencer.sv
// Job controller for one pipelined adder tree: issues chunks, drains the tree, holds the result.
module adder_tree_sequencer
    import adder_tree_seq_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = 8,
    parameter int unsigned INPUT_WIDTH = 8,
    parameter int unsigned TREE_OUT_W  = tree_out_width(NUM_INPUTS, INPUT_WIDTH),
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT     = 8,
    parameter int unsigned ACC_W       = acc_width(TREE_OUT_W, CNT_W)
) (
    input  logic                              clk,
    input  logic                              rst,
    adder_tree_seq_if.slave                   bus,
    output logic [NUM_INPUTS*INPUT_WIDTH-1:0] tree_data_o,
    output logic                              tree_start_o,
    output logic                              tree_final_o,
    output logic                              tree_sigma_o,
    input  logic [TREE_OUT_W-1:0]             tree_sum_i,
    input  logic                              tree_start_i,
    input  logic                              tree_final_i,
    input  logic                              tree_sigma_i,
    output logic                              busy_o,
    output logic                              err_o
);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    seq_state_e        state_q, next_state;
    logic [CNT_W-1:0]  chunks_q;
    logic [CNT_W-1:0]  chunk_cnt_q;
    logic              tag_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              cmd_ready_q, in_ready_q, res_valid_q;
    logic              cmd_hs, in_hs, zero_job, timeout;
    logic              last_chunk_c, tmo_done_c, acc_en_c;

    assign last_chunk_c = (chunk_cnt_q == chunks_q - CNT_W'(1));
    assign tmo_done_c   = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
    assign acc_en_c     = (state_q == ISSUE) || (state_q == DRAIN);

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.in_ready_o  = in_ready_q;
    assign bus.res_valid_o = res_valid_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        cmd_hs     = 1'b0;
        in_hs      = 1'b0;
        zero_job   = 1'b0;
        timeout    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i && cmd_ready_q) begin
                    cmd_hs = 1'b1;
                    if (bus.cmd_chunks_i == '0) begin
                        zero_job   = 1'b1;
                        next_state = HOLD;
                    end else begin
                        next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.in_valid_i && in_ready_q) begin
                    in_hs = 1'b1;
                    if (last_chunk_c) next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (tree_final_i) begin
                    next_state = HOLD;
                end else if (tmo_done_c) begin
                    timeout    = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (bus.res_ready_i && res_valid_q) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake flags follow the next state so they line up with state_q after each edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
            chunks_q     <= '0;
            chunk_cnt_q  <= '0;
            tag_q        <= 1'b0;
            tmo_cnt_q    <= '0;
            tree_data_o  <= '0;
            tree_start_o <= 1'b0;
            tree_final_o <= 1'b0;
            tree_sigma_o <= 1'b0;
        end else begin
            cmd_ready_q  <= (next_state == IDLE);
            in_ready_q   <= (next_state == ISSUE);
            res_valid_q  <= (next_state == HOLD);
            busy_o       <= (next_state != IDLE);
            err_o        <= err_o | timeout;
            tmo_cnt_q    <= (state_q == DRAIN) ? tmo_cnt_q + TMO_W'(1) : '0;
            if (cmd_hs) begin
                chunks_q    <= bus.cmd_chunks_i;
                tag_q       <= bus.cmd_sigma_i;
                chunk_cnt_q <= '0;
            end else if (in_hs) begin
                chunk_cnt_q <= chunk_cnt_q + CNT_W'(1);
            end
            // Cycles without a chunk handshake feed zeros so bubbles add nothing.
            tree_data_o  <= in_hs ? bus.in_data_i : '0;
            tree_start_o <= in_hs && (chunk_cnt_q == '0);
            tree_final_o <= in_hs && last_chunk_c;
            tree_sigma_o <= in_hs && tag_q;
        end
    end

    tree_result_accumulator #(
        .TREE_OUT_W (TREE_OUT_W),
        .ACC_W      (ACC_W)
    ) u_acc (
        .clk          (clk),
        .rst          (rst),
        .en           (acc_en_c),
        .zero_load    (zero_job),
        .timeout_load (timeout),
        .tag          (zero_job ? bus.cmd_sigma_i : tag_q),
        .tree_sum_i   (tree_sum_i),
        .tree_start_i (tree_start_i),
        .tree_final_i (tree_final_i),
        .tree_sigma_i (tree_sigma_i),
        .res_sum_o    (bus.res_sum_o),
        .res_sigma_o  (bus.res_sigma_o)
    );
endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Directed bench for adder_tree_sequencer wrapped with a 3-stage pipelined adder tree model.
module tb_adder_tree_sequencer;
    localparam int unsigned NUM_INPUTS  = 8;
    localparam int unsigned INPUT_WIDTH = 8;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned TIMEOUT     = 8;
    localparam int unsigned TREE_OUT_W  = 11;
    localparam int unsigned ACC_W       = 19;
    localparam int unsigned DATA_W      = NUM_INPUTS * INPUT_WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_tree_seq_if #(
        .NUM_INPUTS (NUM_INPUTS),
        .INPUT_WIDTH(INPUT_WIDTH),
        .CNT_W      (CNT_W),
        .ACC_W      (ACC_W)
    ) bus ();

    logic [DATA_W-1:0]     tree_data_o;
    logic                  tree_start_o, tree_final_o, tree_sigma_o;
    logic [TREE_OUT_W-1:0] tree_sum_i;
    logic                  tree_start_i, tree_final_i, tree_sigma_i;
    logic                  busy_o, err_o;
    logic                  kill_final;

    adder_tree_sequencer #(
        .NUM_INPUTS (NUM_INPUTS),
        .INPUT_WIDTH(INPUT_WIDTH),
        .TREE_OUT_W (TREE_OUT_W),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .ACC_W      (ACC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .tree_data_o (tree_data_o),
        .tree_start_o(tree_start_o),
        .tree_final_o(tree_final_o),
        .tree_sigma_o(tree_sigma_o),
        .tree_sum_i  (tree_sum_i),
        .tree_start_i(tree_start_i),
        .tree_final_i(tree_final_i),
        .tree_sigma_i(tree_sigma_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    // Adder tree model: three register stages, flags travel alongside the sum.
    logic [TREE_OUT_W-1:0] s_sum   [3];
    logic                  s_start [3];
    logic                  s_final [3];
    logic                  s_sigma [3];

    function automatic logic [TREE_OUT_W-1:0] lane_sum(input logic [DATA_W-1:0] d);
        int s;
        s = 0;
        for (int k = 0; k < int'(NUM_INPUTS); k++)
            s += int'($signed(d[k*INPUT_WIDTH +: INPUT_WIDTH]));
        return TREE_OUT_W'(s);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                s_sum[i] <= '0; s_start[i] <= 1'b0; s_final[i] <= 1'b0; s_sigma[i] <= 1'b0;
            end
        end else begin
            s_sum[0] <= lane_sum(tree_data_o);
            s_start[0] <= tree_start_o; s_final[0] <= tree_final_o; s_sigma[0] <= tree_sigma_o;
            for (int i = 1; i < 3; i++) begin
                s_sum[i] <= s_sum[i-1]; s_start[i] <= s_start[i-1];
                s_final[i] <= s_final[i-1]; s_sigma[i] <= s_sigma[i-1];
            end
        end
    end

    assign tree_sum_i   = s_sum[2];
    assign tree_start_i = s_start[2];
    assign tree_final_i = s_final[2] & ~kill_final;
    assign tree_sigma_i = s_sigma[2];

    int start_o_cnt = 0;
    int same_cnt    = 0;
    always @(posedge clk) begin
        if (tree_start_o) start_o_cnt <= start_o_cnt + 1;
        if (tree_start_i && tree_final_i) same_cnt <= same_cnt + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint res_val();
        return longint'($signed(bus.res_sum_o));
    endfunction

    function automatic logic [DATA_W-1:0] fill(input logic [INPUT_WIDTH-1:0] b);
        return {NUM_INPUTS{b}};
    endfunction

    task automatic send_cmd(input int n, input logic tag);
        int k;
        k = 0;
        bus.cmd_valid_i  = 1'b1;
        bus.cmd_chunks_i = CNT_W'(n);
        bus.cmd_sigma_i  = tag;
        while (!bus.cmd_ready_o && k < 50) begin @(negedge clk); k++; end
        if (!bus.cmd_ready_o) check("cmd_accept", longint'(bus.cmd_ready_o), 1);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic send_chunk(input logic [DATA_W-1:0] d, input int gap);
        int k;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("bubble_data", longint'(tree_data_o), 0);
        end
        k = 0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
        while (!bus.in_ready_o && k < 50) begin @(negedge clk); k++; end
        if (!bus.in_ready_o) check("chunk_accept", longint'(bus.in_ready_o), 1);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = '0;
    endtask

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!bus.res_valid_o && cyc < 40) begin @(negedge clk); cyc++; end
        if (!bus.res_valid_o) check("res_wait", longint'(bus.res_valid_o), 1);
    endtask

    task automatic take_result();
        bus.res_ready_i = 1'b1;
        @(negedge clk);
        bus.res_ready_i = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int snap;
        logic [DATA_W-1:0] ramp;

        rst = 1'b1;
        kill_final = 1'b0;
        bus.cmd_valid_i = 1'b0; bus.cmd_chunks_i = '0; bus.cmd_sigma_i = 1'b0;
        bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.res_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", longint'(bus.cmd_ready_o), 0);
        check("rst_res_valid", longint'(bus.res_valid_o), 0);
        check("rst_busy", longint'(busy_o), 0);
        check("rst_err", longint'(err_o), 0);
        check("rst_res_sum", res_val(), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_cmd_ready", longint'(bus.cmd_ready_o), 1);

        // 3 chunks of +1 lanes, tag 1
        send_cmd(3, 1'b1);
        check("issue_busy", longint'(busy_o), 1);
        check("issue_in_ready", longint'(bus.in_ready_o), 1);
        for (int i = 0; i < 3; i++) send_chunk(fill(8'd1), 0);
        wait_result(cyc);
        check("j1_latency", cyc, 4);
        check("j1_sum", res_val(), 24);
        check("j1_sigma", longint'(bus.res_sigma_o), 1);
        check("j1_no_same", same_cnt, 0);
        take_result();
        check("j1_valid_drop", longint'(bus.res_valid_o), 0);

        // 1 chunk of -128 lanes
        send_cmd(1, 1'b0);
        send_chunk(fill(8'h80), 0);
        wait_result(cyc);
        check("j2_sum", res_val(), -1024);
        check("j2_sigma", longint'(bus.res_sigma_o), 0);
        check("j2_same_cycle", same_cnt, 1);
        take_result();

        // zero-chunk job
        snap = start_o_cnt;
        send_cmd(0, 1'b1);
        wait_result(cyc);
        check("j3_latency", cyc, 0);
        check("j3_sum", res_val(), 0);
        check("j3_sigma", longint'(bus.res_sigma_o), 1);
        repeat (3) @(negedge clk);
        check("j3_no_start", start_o_cnt - snap, 0);
        take_result();

        // 4 ramp chunks with input gaps
        ramp = '0;
        for (int k = 0; k < int'(NUM_INPUTS); k++) ramp[k*INPUT_WIDTH +: INPUT_WIDTH] = INPUT_WIDTH'(k + 1);
        send_cmd(4, 1'b0);
        send_chunk(ramp, 0);
        send_chunk(ramp, 3);
        send_chunk(ramp, 5);
        send_chunk(ramp, 1);
        wait_result(cyc);
        check("j4_sum", res_val(), 144);
        take_result();

        // result held under back-pressure, next command waiting
        send_cmd(2, 1'b0);
        send_chunk(fill(8'd2), 0);
        send_chunk(fill(8'd2), 0);
        wait_result(cyc);
        bus.cmd_valid_i = 1'b1; bus.cmd_chunks_i = '0; bus.cmd_sigma_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_sum", res_val(), 32);
            check("hold_cmd_ready", longint'(bus.cmd_ready_o), 0);
        end
        check("hold_valid", longint'(bus.res_valid_o), 1);
        take_result();
        check("post_hs_valid", longint'(bus.res_valid_o), 0);
        check("post_hs_cmd_ready", longint'(bus.cmd_ready_o), 1);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        check("next_cmd_valid", longint'(bus.res_valid_o), 1);
        check("next_cmd_sigma", longint'(bus.res_sigma_o), 1);
        take_result();

        // reset in the middle of a job
        send_cmd(3, 1'b1);
        send_chunk(fill(8'd10), 0);
        pulse_reset();
        check("mid_rst_busy", longint'(busy_o), 0);
        check("mid_rst_valid", longint'(bus.res_valid_o), 0);
        send_cmd(2, 1'b0);
        send_chunk(fill(8'd3), 0);
        send_chunk(fill(8'd3), 0);
        wait_result(cyc);
        check("j6_sum", res_val(), 48);
        check("j6_sigma", longint'(bus.res_sigma_o), 0);
        take_result();
        check("pre_tmo_err", longint'(err_o), 0);

        // tree final flag lost: drain must time out
        kill_final = 1'b1;
        send_cmd(1, 1'b1);
        send_chunk(fill(8'd1), 0);
        wait_result(cyc);
        check("tmo_cycles", cyc, int'(TIMEOUT));
        check("tmo_err", longint'(err_o), 1);
        check("tmo_sum", res_val(), 8);
        check("tmo_sigma", longint'(bus.res_sigma_o), 1);
        take_result();
        check("tmo_err_sticky", longint'(err_o), 1);
        kill_final = 1'b0;
        pulse_reset();
        check("err_cleared", longint'(err_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
